adjust_controller: RTL and testbench

Time-set sequencer for the clock. It takes the conditioned mode button and the conditioned adjust button (the output of the adjust delay/debounce stage). It walks the setting mode through the hour, minute and second fields, and issues single-cycle increment pulses to the selected counter field, with auto-repeat while adjust is held. It also tells the timekeeping counters when to pause and drives the display blink for the selected field.

---
 rtl/adjust_controller.sv | 175 +++++++++++++++++
 tb/tb_adjust_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adjust_controller.sv
// Time-set sequencer: walks the setting mode through hour/minute/second, issues
// single-cycle increment pulses with auto-repeat, handles inactivity timeout and
// drives the blink for the selected field. All outputs come straight from flops.
module adjust_controller #(
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned REPEAT_CYCLES  = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned BLINK_CYCLES   = 25_000_000
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       mode,
  input  logic       adjust,
  output logic       setting,
  output logic [1:0] sel,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_sec,
  output logic       blink
);

  localparam int unsigned MaxHr  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned MaxTb  = (TIMEOUT_CYCLES > BLINK_CYCLES) ? TIMEOUT_CYCLES : BLINK_CYCLES;
  localparam int unsigned MaxCyc = (MaxHr > MaxTb) ? MaxHr : MaxTb;
  localparam int unsigned CntW   = $clog2(MaxCyc);

  localparam logic [CntW-1:0] HoldLast    = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RepeatLast  = CntW'(REPEAT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] BlinkLast   = CntW'(BLINK_CYCLES - 1);

  // Encoding doubles as the sel output value.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StHour = 2'b01,
    StMin  = 2'b10,
    StSec  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic            setting_q, setting_d;
  logic            inc_hour_q, inc_hour_d;
  logic            inc_min_q, inc_min_d;
  logic            inc_sec_q, inc_sec_d;
  logic            blink_q, blink_d;
  logic            mode_prev_q, adj_prev_q;
  logic            armed_q, armed_d;   // a pulse was issued and adjust is still held
  logic            rep_q, rep_d;       // past the initial hold delay, in repeat phase
  logic [CntW-1:0] hold_q, hold_d;
  logic [CntW-1:0] inact_q, inact_d;
  logic [CntW-1:0] bcnt_q, bcnt_d;

  logic mode_edge, adj_edge, pulse;

  assign mode_edge = mode & ~mode_prev_q;
  assign adj_edge  = adjust & ~adj_prev_q;

  // Next state, pulse generation, hold/repeat and inactivity counters.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    rep_d   = rep_q;
    hold_d  = hold_q;
    inact_d = inact_q;
    pulse   = 1'b0;
    if (state_q == StIdle) begin
      armed_d = 1'b0;
      rep_d   = 1'b0;
      hold_d  = '0;
      inact_d = '0;
      if (mode_edge) state_d = StHour;
    end else if (mode_edge) begin
      // Mode wins over any adjust activity in the same cycle.
      unique case (state_q)
        StHour:  state_d = StMin;
        StMin:   state_d = StSec;
        default: state_d = StIdle;
      endcase
      armed_d = 1'b0;
      rep_d   = 1'b0;
      hold_d  = '0;
      inact_d = '0;
    end else if (adjust) begin
      inact_d = '0;
      if (adj_edge) begin
        pulse   = 1'b1;
        armed_d = 1'b1;
        rep_d   = 1'b0;
        hold_d  = '0;
      end else if (armed_q) begin
        if (hold_q == (rep_q ? RepeatLast : HoldLast)) begin
          pulse  = 1'b1;
          rep_d  = 1'b1;
          hold_d = '0;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
    end else begin
      armed_d = 1'b0;
      rep_d   = 1'b0;
      hold_d  = '0;
      if (inact_q == TimeoutLast) begin
        state_d = StIdle;
        inact_d = '0;
      end else if (inact_q != '1) begin
        inact_d = inact_q + 1'b1;
      end
    end
  end

  // Registered outputs: setting, increment pulses and blink phase.
  always_comb begin
    setting_d  = (state_d != StIdle);
    inc_hour_d = pulse && (state_q == StHour);
    inc_min_d  = pulse && (state_q == StMin);
    inc_sec_d  = pulse && (state_q == StSec);
    blink_d    = blink_q;
    bcnt_d     = bcnt_q;
    if (state_d == StIdle) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if ((state_d != state_q) || pulse) begin
      // Show the field on entry and whenever a digit changes.
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (bcnt_q == BlinkLast) begin
      blink_d = ~blink_q;
      bcnt_d  = '0;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= StIdle;
      setting_q   <= 1'b0;
      inc_hour_q  <= 1'b0;
      inc_min_q   <= 1'b0;
      inc_sec_q   <= 1'b0;
      blink_q     <= 1'b0;
      mode_prev_q <= 1'b0;
      adj_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      rep_q       <= 1'b0;
      hold_q      <= '0;
      inact_q     <= '0;
      bcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      setting_q   <= setting_d;
      inc_hour_q  <= inc_hour_d;
      inc_min_q   <= inc_min_d;
      inc_sec_q   <= inc_sec_d;
      blink_q     <= blink_d;
      mode_prev_q <= mode;
      adj_prev_q  <= adjust;
      armed_q     <= armed_d;
      rep_q       <= rep_d;
      hold_q      <= hold_d;
      inact_q     <= inact_d;
      bcnt_q      <= bcnt_d;
    end
  end

  assign setting  = setting_q;
  assign sel      = state_q;
  assign inc_hour = inc_hour_q;
  assign inc_min  = inc_min_q;
  assign inc_sec  = inc_sec_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_adjust_controller.sv
// Bench for adjust_controller: directed scenarios with literal expectations plus
// randomized stimulus checked every cycle against an event-time reference model.
module tb_adjust_controller;
  localparam int unsigned H = 8;
  localparam int unsigned R = 4;
  localparam int unsigned T = 32;
  localparam int unsigned B = 4;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       mode = 1'b0;
  logic       adjust = 1'b0;
  logic       setting, inc_hour, inc_min, inc_sec, blink;
  logic [1:0] sel;

  adjust_controller #(
    .HOLD_CYCLES   (H),
    .REPEAT_CYCLES (R),
    .TIMEOUT_CYCLES(T),
    .BLINK_CYCLES  (B)
  ) dut (
    .clk     (clk),
    .clear   (clear),
    .mode    (mode),
    .adjust  (adjust),
    .setting (setting),
    .sel     (sel),
    .inc_hour(inc_hour),
    .inc_min (inc_min),
    .inc_sec (inc_sec),
    .blink   (blink)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  // Reference model state, expressed as event times rather than counters.
  int         now_c = 0;
  int         m_field = 0;
  int         m_press_t = 0;
  int         m_last_act = 0;
  int         m_restart = 0;
  bit         m_prev_mode = 0;
  bit         m_prev_adj = 0;
  bit         m_press_valid = 0;
  bit         m_valid = 0;
  logic [7:0] exp_vec = '0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Advance the model by one rising edge using the inputs sampled at that edge.
  task automatic model_step();
    bit me, ae, pulse, bl;
    int old, e;
    now_c++;
    if (clear) begin
      m_field = 0;
      m_prev_mode = 0;
      m_prev_adj = 0;
      m_press_valid = 0;
      m_last_act = now_c;
      m_restart = now_c;
      exp_vec = '0;
      m_valid = 1;
      return;
    end
    me = mode && !m_prev_mode;
    ae = adjust && !m_prev_adj;
    m_prev_mode = mode;
    m_prev_adj = adjust;
    pulse = 0;
    old = m_field;
    if (m_field == 0) begin
      m_press_valid = 0;
      m_last_act = now_c;
      if (me) m_field = 1;
    end else if (me) begin
      m_field = (m_field + 1) % 4;
      m_press_valid = 0;
      m_last_act = now_c;
    end else if (adjust) begin
      m_last_act = now_c;
      if (ae) begin
        m_press_t = now_c;
        m_press_valid = 1;
        pulse = 1;
      end else if (m_press_valid) begin
        e = now_c - m_press_t;
        pulse = (e >= int'(H)) && (((e - int'(H)) % int'(R)) == 0);
      end
    end else begin
      m_press_valid = 0;
      if (now_c - m_last_act >= int'(T)) m_field = 0;
    end
    if (m_field == 0) begin
      bl = 0;
    end else if (m_field != old || pulse) begin
      m_restart = now_c;
      bl = 1;
    end else begin
      bl = (((now_c - m_restart) / int'(B)) % 2) == 0;
    end
    exp_vec = {m_field != 0, 2'(m_field), pulse && m_field == 1, pulse && m_field == 2,
               pulse && m_field == 3, bl};
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        got = {setting, sel, inc_hour, inc_min, inc_sec, blink};
        n_vec++;
        if (got !== exp_vec) begin
          n_err++;
          $display("FAIL cycle %0d outputs {setting,sel,inc_h,inc_m,inc_s,blink}: got %b, expected %b",
                   now_c, got, exp_vec);
        end
        if (inc_hour || inc_min || inc_sec) pulse_cnt++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press_mode(input int exp_sel);
    mode = 1'b1;
    tick();
    check("sel after mode edge", int'(sel), exp_sel);
    check("setting follows sel", int'(setting), int'(exp_sel != 0));
    tick();
    mode = 1'b0;
    tick(3);
  endtask

  // Counts cycles until sel returns to 0, bounded.
  task automatic wait_idle(output int k);
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (sel == 2'b00) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int p0, k, adj_run;
    // 1: reset and adjust ignored in IDLE
    tick(3);
    check("reset setting", int'(setting), 0);
    check("reset sel", int'(sel), 0);
    check("reset inc", int'({inc_hour, inc_min, inc_sec}), 0);
    check("reset blink", int'(blink), 0);
    clear = 1'b0;
    tick();
    p0 = pulse_cnt;
    for (int i = 0; i < 20; i++) begin
      adjust = i[1];
      tick();
    end
    adjust = 1'b0;
    tick(2);
    check("pulses in idle", pulse_cnt - p0, 0);
    // 2: mode walks through the fields
    press_mode(1);
    press_mode(2);
    press_mode(3);
    press_mode(0);
    // 3: single press and auto-repeat in SET_MIN
    press_mode(1);
    press_mode(2);
    p0 = pulse_cnt;
    adjust = 1'b1;
    tick();
    check("inc_min one cycle after edge", int'(inc_min), 1);
    tick(2);
    adjust = 1'b0;
    tick(2);
    check("pulses for short press", pulse_cnt - p0, 1);
    p0 = pulse_cnt;
    adjust = 1'b1;
    tick(30);
    adjust = 1'b0;
    tick(2);
    check("pulses for 30-cycle hold", pulse_cnt - p0, 7);
    // 4: mode and adjust edges together
    press_mode(3);
    press_mode(0);
    press_mode(1);
    p0 = pulse_cnt;
    mode = 1'b1;
    adjust = 1'b1;
    tick();
    check("sel after simultaneous edges", int'(sel), 2);
    check("no inc on simultaneous edges", int'({inc_hour, inc_min, inc_sec}), 0);
    tick();
    mode = 1'b0;
    tick(18);
    check("no pulse while still held", pulse_cnt - p0, 0);
    adjust = 1'b0;
    tick(2);
    adjust = 1'b1;
    tick();
    check("inc_min after repress", int'(inc_min), 1);
    adjust = 1'b0;
    tick(2);
    // 5: timeout from SET_SEC
    mode = 1'b1;
    tick();
    check("sel entering SET_SEC", int'(sel), 3);
    mode = 1'b0;
    wait_idle(k);
    check("idle timeout cycles", k, 32);
    press_mode(1);
    press_mode(2);
    mode = 1'b1;
    tick();
    mode = 1'b0;
    tick(19);
    adjust = 1'b1;
    tick(2);
    adjust = 1'b0;
    wait_idle(k);
    check("timeout after release", k, 32);
    // 6: clear mid-hold
    press_mode(1);
    adjust = 1'b1;
    tick(10);
    clear = 1'b1;
    tick();
    check("clear sel", int'(sel), 0);
    check("clear setting", int'(setting), 0);
    check("clear inc_hour", int'(inc_hour), 0);
    check("clear blink", int'(blink), 0);
    clear = 1'b0;
    p0 = pulse_cnt;
    tick(15);
    check("no pulse after clear", pulse_cnt - p0, 0);
    adjust = 1'b0;
    tick(2);
    // Randomized traffic
    adj_run = 0;
    for (int i = 0; i < 3000; i++) begin
      clear = ($urandom_range(0, 299) == 0);
      mode = ($urandom_range(0, 24) == 0);
      if (adj_run == 0) begin
        adjust = ~adjust;
        adj_run = adjust ? $urandom_range(1, 40) : $urandom_range(1, 45);
      end
      adj_run--;
      tick();
    end
    clear = 1'b0;
    mode = 1'b0;
    adjust = 1'b0;
    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
